// File: rtl/div_pkg.sv
// div_pkg: shared FSM encoding and counter sizing for seq_divider_hs
package div_pkg;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t CALC  = 2'd1;
    localparam state_t FIXUP = 2'd2;
    localparam state_t DONE  = 2'd3;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/seq_divider_hs_step.sv
// div_step: one restoring-division step on unsigned magnitudes
// rem/quo/den: current partial remainder, shifting dividend/quotient, divisor
// next_rem/next_quo: values after one shift-and-subtract
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    // rem stays below 2^(WIDTH-1) until the last step, so dropping its MSB loses nothing
    always_comb begin
        shifted  = {rem[WIDTH-2:0], quo[WIDTH-1]};
        trial    = {1'b0, shifted} - {1'b0, den};
        next_rem = trial[WIDTH] ? shifted : trial[WIDTH-1:0];
        next_quo = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end
endmodule

// File: rtl/seq_divider_hs.sv
// seq_divider_hs: multi-cycle restoring divider with valid/ready on operands and results
// in_valid/in_ready/dividend/divisor/op_signed: operand handshake, accepted only in IDLE
// out_valid/out_ready/quotient/remainder/div_by_zero: result handshake, held in DONE
// busy: high while iterating (CALC) or applying signs (FIXUP)
module seq_divider_hs
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             op_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, den_q, den_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dbz_q, dbz_d;
    logic [WIDTH-1:0] next_rem, next_quo;
    logic             a_neg, b_neg, zero_div;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem_q), .quo(quo_q), .den(den_q),
        .next_rem(next_rem), .next_quo(next_quo)
    );

    always_comb begin
        a_neg       = SIGNED_EN && op_signed && dividend[WIDTH-1];
        b_neg       = SIGNED_EN && op_signed && divisor[WIDTH-1];
        zero_div    = divisor == '0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        den_d       = den_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d   = zero_div ? DONE : CALC;
                cnt_d     = CW'(WIDTH - 1);
                rem_d     = '0;
                quo_d     = a_neg ? -dividend : dividend;
                den_d     = b_neg ? -divisor : divisor;
                neg_quo_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                dbz_d     = zero_div;
                // zero divisor skips iteration: results are fixed at accept time
                quotient_d  = zero_div ? '1 : quotient_q;
                remainder_d = zero_div ? dividend : remainder_q;
            end
            CALC: begin
                rem_d   = next_rem;
                quo_d   = next_quo;
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? FIXUP : CALC;
            end
            FIXUP: begin
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                state_d     = DONE;
            end
            default: state_d = out_ready ? IDLE : DONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            den_q       <= den_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = state_q == IDLE;
    assign out_valid   = state_q == DONE;
    assign busy        = state_q == CALC || state_q == FIXUP;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_hs.sv
// tb_seq_divider_hs: scoreboard bench for two 32-bit instances (signed/unsigned-only) and one 8-bit instance
module tb_seq_divider_hs;
    typedef struct {
        longint unsigned q;
        longint unsigned r;
        bit              dz;
    } exp_t;

    logic        clk = 0, reset = 1, ordy = 0;
    logic        iv32 = 0, s32 = 0, iv8 = 0, s8 = 0;
    logic [31:0] a32 = 0, b32 = 0, q0, r0, q1, r1;
    logic [7:0]  a8 = 0, b8 = 0, q2, r2;
    logic [2:0]  ir, ov, bz, dz;

    always #5 clk = ~clk;

    seq_divider_hs #(.WIDTH(32), .SIGNED_EN(1)) u0 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir[0]), .dividend(a32), .divisor(b32),
        .op_signed(s32), .out_valid(ov[0]), .out_ready(ordy), .quotient(q0), .remainder(r0),
        .div_by_zero(dz[0]), .busy(bz[0]));
    seq_divider_hs #(.WIDTH(32), .SIGNED_EN(0)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(ir[1]), .dividend(a32), .divisor(b32),
        .op_signed(s32), .out_valid(ov[1]), .out_ready(ordy), .quotient(q1), .remainder(r1),
        .div_by_zero(dz[1]), .busy(bz[1]));
    seq_divider_hs #(.WIDTH(8), .SIGNED_EN(1)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir[2]), .dividend(a8), .divisor(b8),
        .op_signed(s8), .out_valid(ov[2]), .out_ready(ordy), .quotient(q2), .remainder(r2),
        .div_by_zero(dz[2]), .busy(bz[2]));

    longint unsigned oq [3], orr [3], bin [3];
    logic            ivv [3];
    int              wd [3] = '{32, 32, 8};
    assign oq[0] = 64'(q0);
    assign oq[1] = 64'(q1);
    assign oq[2] = 64'(q2);
    assign orr[0] = 64'(r0);
    assign orr[1] = 64'(r1);
    assign orr[2] = 64'(r2);
    assign bin[0] = 64'(b32);
    assign bin[1] = 64'(b32);
    assign bin[2] = 64'(b8);
    assign ivv[0] = iv32;
    assign ivv[1] = iv32;
    assign ivv[2] = iv8;

    exp_t sb [3][$];
    int   cyc = 0, n_cmp = 0, n_bad = 0, drv_to = 0;
    bit   fin = 0, fin_ack = 0, bp_mode = 0, bp_val = 1;
    bit   infl [3];
    int   acc_c [3], lat [3];
    longint unsigned lq [3], lr [3];
    bit   ldz [3];

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1 ordy = bp_mode ? bp_val : ($urandom_range(0, 3) != 0);
    end

    // Signed results use plain 64-bit signed arithmetic, which truncates toward zero.
    function automatic exp_t model(input longint unsigned a, input longint unsigned b, input int w, input bit sg);
        exp_t            e;
        longint unsigned m;
        longint          sa, sd, tq, tr;
        m  = (64'd1 << w) - 1;
        a  = a & m;
        b  = b & m;
        sa = longint'(a << (64 - w)) >>> (64 - w);
        sd = longint'(b << (64 - w)) >>> (64 - w);
        if (b == 0) begin
            e.q = m; e.r = a; e.dz = 1;
        end else if (sg) begin
            tq = sa / sd; tr = sa % sd;
            e.q = m & tq; e.r = m & tr; e.dz = 0;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input longint unsigned act, input longint unsigned want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s[u%0d] cycle %0d: got %h want %h", nm, i, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                chk("rst_in_ready", i, ir[i], 1);
                chk("rst_out_valid", i, ov[i], 0);
                chk("rst_busy", i, bz[i], 0);
                chk("rst_quotient", i, oq[i], 0);
                chk("rst_remainder", i, orr[i], 0);
                chk("rst_dbz", i, dz[i], 0);
                sb[i].delete();
                infl[i] = 0; lq[i] = 0; lr[i] = 0; ldz[i] = 0;
            end else begin
                int since;
                since = cyc - acc_c[i];
                chk("in_ready", i, ir[i], !infl[i]);
                chk("out_valid", i, ov[i], infl[i] && since >= lat[i]);
                chk("busy", i, bz[i], infl[i] && lat[i] != 1 && since >= 1 && since <= wd[i] + 1);
                if (ov[i]) begin
                    chk("sb_depth", i, sb[i].size(), 1);
                    if (sb[i].size() != 0) begin
                        chk("quotient", i, oq[i], sb[i][0].q);
                        chk("remainder", i, orr[i], sb[i][0].r);
                        chk("div_by_zero", i, dz[i], sb[i][0].dz);
                    end
                    lq[i] = oq[i]; lr[i] = orr[i]; ldz[i] = dz[i];
                    if (ordy) begin
                        if (sb[i].size() != 0) void'(sb[i].pop_front());
                        infl[i] = 0;
                    end
                end else begin
                    chk("quotient_hold", i, oq[i], lq[i]);
                    chk("remainder_hold", i, orr[i], lr[i]);
                    chk("dbz_hold", i, dz[i], infl[i] ? 0 : ldz[i]);
                end
                if (ivv[i] && ir[i]) begin
                    infl[i]  = 1;
                    acc_c[i] = cyc;
                    lat[i]   = bin[i] == 0 ? 1 : wd[i] + 2;
                end
            end
        end
        if (fin && !fin_ack) begin
            chk("driver_timeout", 0, drv_to, 0);
            for (int i = 0; i < 3; i++) chk("sb_leftover", i, sb[i].size(), 0);
            fin_ack = 1;
        end
    end

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input bit s, input bit keep);
        bit acc = 0;
        a32 = a; b32 = b; s32 = s; iv32 = 1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = ir[0];
            @(posedge clk);
        end
        if (!acc) drv_to++;
        else begin
            sb[0].push_back(model(64'(a), 64'(b), 32, s));
            sb[1].push_back(model(64'(a), 64'(b), 32, 0));
        end
        #1 if (!keep) iv32 = 0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit s, input bit keep);
        bit acc = 0;
        a8 = a; b8 = b; s8 = s; iv8 = 1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = ir[2];
            @(posedge clk);
        end
        if (!acc) drv_to++;
        else sb[2].push_back(model(64'(a), 64'(b), 8, s));
        #1 if (!keep) iv8 = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (t < 500 && (infl[0] || infl[1] || infl[2])) begin
            @(posedge clk);
            t++;
        end
        if (t == 500) drv_to++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'($urandom_range(1, 15));
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 0;
        bp_mode = 1; bp_val = 1;
        send32(32'd100, 32'd7, 0, 0);
        send32(32'hFFFF_FFF9, 32'd2, 1, 0);
        send32(32'd7, 32'hFFFF_FFFE, 1, 0);
        send32(32'hFFFF_FFF9, 32'd2, 0, 0);
        send32(32'h1234, 32'd0, 1, 0);
        send32(32'd9, 32'd3, 0, 0);
        send32(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        wait_idle();
        bp_val = 0;
        send32(32'd50, 32'd6, 0, 1);
        for (int t = 0; t < 100 && !ov[0]; t++) @(posedge clk);
        repeat (5) @(posedge clk);
        bp_val = 1;
        send32(32'd8, 32'hFFFF_FFFE, 1, 0);
        wait_idle();
        bp_mode = 0;
        for (int j = 0; j < 40; j++) send32(pick32(), pick32(), 1'($urandom), j != 39 && $urandom_range(0, 1) == 1);
        wait_idle();
        send32(32'd1000, 32'd3, 0, 0);
        repeat (10) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #2 reset = 0;
        send8(8'd255, 8'd16, 0, 0);
        send8(8'h80, 8'hFF, 1, 0);
        send8(8'hF9, 8'd2, 1, 0);
        send8(8'd5, 8'd0, 1, 0);
        send8(8'd77, 8'd9, 0, 0);
        for (int j = 0; j < 40; j++)
            send8(8'($urandom), $urandom_range(0, 4) == 0 ? 8'd0 : 8'($urandom), 1'($urandom), j != 39 && $urandom_range(0, 1) == 1);
        wait_idle();
        fin = 1;
        for (int t = 0; t < 10 && !fin_ack; t++) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_divider_hs.md
Name: seq_divider_hs

Overview:
Parametrised multi-cycle restoring divider, signed or unsigned per operation, with valid/ready handshakes on both the operand and result sides. It is the general-purpose successor to the fixed 32-bit start/ok divider in the datapath library. It adds a width parameter, per-request signed mode, result backpressure, and explicit divide-by-zero handling. It sits between an issue stage (producer) and a writeback stage (consumer).

Parameters:
WIDTH, 32, operand/result width in bits (legal range 4..64)
SIGNED_EN, 1, 1 = honour op_signed; 0 = op_signed ignored, all operations unsigned

Ports:
clk  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
in_valid  in  1  operand request valid
in_ready  out  1  block can accept a request (high only in IDLE)
dividend  in  WIDTH  numerator, sampled on in_valid&&in_ready
divisor  in  WIDTH  denominator, sampled on in_valid&&in_ready
op_signed  in  1  two's-complement operation, sampled with operands
out_valid  out  1  result valid (high only in DONE)
out_ready  in  1  consumer accepts result
quotient  out  WIDTH  result quotient
remainder  out  WIDTH  result remainder
div_by_zero  out  1  current result came from a zero divisor
busy  out  1  high in CALC or FIXUP

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; in_ready=1; out_valid=0; busy=0; quotient=0; remainder=0; div_by_zero=0; iteration counter=0. An in-flight operation is discarded with no output.
- FSM states and transitions:
  - IDLE -> CALC on accept when divisor!=0.
  - IDLE -> DONE on accept when divisor==0.
  - CALC -> FIXUP when the iteration counter reaches 0.
  - FIXUP -> DONE unconditionally.
  - DONE -> IDLE on out_ready.
- Accept: the handshake is in_valid&&in_ready.
  - Latch |dividend| and |divisor| when signed mode is active; raw values otherwise.
  - Latch neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend). Both are forced to 0 when unsigned.
  - Load the counter with WIDTH-1. Counter width is $clog2(WIDTH).
- CALC, one restoring step per cycle:
  - trial = {rem[WIDTH-2:0], quo[WIDTH-1]} - den, computed WIDTH+1 bits wide.
  - If trial is non-negative: rem=trial[WIDTH-1:0] and shift 1 into quo.
  - Otherwise: rem takes the shifted value and shift 0 into quo.
  - The counter decrements each cycle. CALC lasts exactly WIDTH cycles.
- FIXUP: quotient = neg_q ? -quo : quo; remainder = neg_r ? -rem : rem. Both are registered.
- Latency: out_valid is first high exactly WIDTH+2 cycles after the accept edge (normal path) and 1 cycle after it (zero divisor).
- Divide by zero: quotient = all ones, remainder = dividend as sampled (raw, unnegated), div_by_zero=1. This applies in both signed and unsigned mode.
- Signed overflow MIN / -1: quotient = MIN, remainder = 0, div_by_zero=0. This falls out of the magnitude arithmetic; no special case is required, but it must be verified.
- Sign rules: quotient truncates toward zero; a nonzero remainder carries the sign of the dividend.
- DONE and backpressure:
  - quotient, remainder and div_by_zero stay stable while out_valid && !out_ready.
  - Outputs hold their last values after leaving DONE.
  - div_by_zero clears on the next accept.
- No back-to-back throughput: in_ready rises the cycle after the out handshake. A request presented during DONE is not accepted until IDLE.
- Operand inputs are ignored outside IDLE.
- in_valid may be held high across operations; each acceptance is one operation.

Decomposition:
- Shared package div_pkg: state enum (IDLE, CALC, FIXUP, DONE), 2-bit state encoding, and the function for the counter-width constant.
- Sub-module div_step (combinational, WIDTH-parametrised): inputs rem, quo, den; outputs next_rem, next_quo.
- The top level holds the FSM, counter, sign flags and output registers.

Test Plan:
- WIDTH=32, unsigned 100/7, out_ready=1: accept at cycle 0 -> out_valid at cycle 34, q=14, r=2, div_by_zero=0, busy high cycles 1..33.
- Signed -7/2 -> q=-3 (0xFFFFFFFD), r=-1; signed 7/-2 -> q=-3, r=1; same -7 operands with op_signed=0 and SIGNED_EN=0 instance -> unsigned result 0xFFFFFFF9/2 = q=0x7FFFFFFC, r=1.
- Divisor 0, dividend 0x1234, signed -> out_valid 1 cycle after accept, q=0xFFFFFFFF, r=0x1234, div_by_zero=1; next op 9/3 -> q=3, r=0, div_by_zero=0.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, no error.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0 throughout; in_ready=1 the cycle after out_ready=1.
- Assert reset for 1 cycle at CALC cycle 10 -> all outputs at reset values immediately; next request 255/16 on a WIDTH=8 instance -> q=15, r=15 after 10 cycles.
